// File: rtl/rx_bit_timer.sv
// ---------------------------------------------------------------------------
// rx_bit_timer
//
// Receive-side timing controller for the serial receiver. A one-cycle start
// pulse launches a frame. The controller then emits one mid-bit shift strobe
// for each data bit and for the stop bit. After the stop-bit period it checks
// the stop bit and either pulses load_buffer or raises framing_error.
//
// Ports
//   clk                 in   system clock, rising edge
//   n_rst               in   synchronous active-low reset
//   start_bit_detected  in   one-cycle pulse from the start-bit detector
//   stop_bit            in   last bit shifted in (1 = valid stop bit)
//   shift_strobe        out  one-cycle pulse, shift register samples line
//   packet_done         out  one-cycle pulse, all DATA_BITS+1 bits shifted
//   load_buffer         out  one-cycle pulse, RX buffer captures data
//   framing_error       out  level, stop bit of last frame was 0
//   busy                out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic stop_bit,
    output logic shift_strobe,
    output logic packet_done,
    output logic load_buffer,
    output logic framing_error,
    output logic busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 2);

    localparam logic [CW-1:0] CYC_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    // Bit counter value 0 is the start bit; 1..DATA_BITS are data bits and
    // DATA_BITS+1 is the stop bit, which is the last period of the frame.
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECEIVE,
        S_CHECK,
        S_LOAD
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cyc;
    logic [BW-1:0]   r_bit;
    logic            r_framing_error;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state         <= S_IDLE;
            r_cyc           <= '0;
            r_bit           <= '0;
            r_framing_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_bit_detected) begin
                        r_state         <= S_RECEIVE;
                        r_cyc           <= '0;
                        r_bit           <= '0;
                        r_framing_error <= 1'b0;
                    end
                end

                S_RECEIVE: begin
                    if (r_cyc == CYC_LAST) begin
                        r_cyc <= '0;
                        // Leave at the end of the stop-bit period instead of
                        // advancing, so the bit counter never wraps.
                        if (r_bit == BIT_LAST) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (stop_bit) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_framing_error <= 1'b1;
                        r_state         <= S_IDLE;
                    end
                end

                S_LOAD: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so no input can reach
    // an output within the same cycle. The strobe excludes bit 0 (start bit).
    logic w_strobe;
    assign w_strobe = (r_state == S_RECEIVE) && (r_cyc == CYC_MID) && (r_bit != '0);

    assign shift_strobe  = w_strobe;
    assign packet_done   = (r_state == S_CHECK);
    assign load_buffer   = (r_state == S_LOAD);
    assign framing_error = r_framing_error;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_rx_bit_timer
//
// Two instances: default parameters (a) and CLKS_PER_BIT=9, DATA_BITS=5 (b).
// Outputs are sampled on the falling edge, i.e. in the middle of a period.
// Output vector order: {shift_strobe, packet_done, load_buffer,
// framing_error, busy}.
// ---------------------------------------------------------------------------
module tb_rx_bit_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic start_a, stop_a, start_b, stop_b;
    logic strobe_a, pd_a, lb_a, fe_a, busy_a;
    logic strobe_b, pd_b, lb_b, fe_b, busy_b;
    logic [4:0] obs_a, obs_b;

    assign obs_a = {strobe_a, pd_a, lb_a, fe_a, busy_a};
    assign obs_b = {strobe_b, pd_b, lb_b, fe_b, busy_b};

    rx_bit_timer #(.CLKS_PER_BIT(10), .DATA_BITS(8)) u_dut_a (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_a),
        .stop_bit           (stop_a),
        .shift_strobe       (strobe_a),
        .packet_done        (pd_a),
        .load_buffer        (lb_a),
        .framing_error      (fe_a),
        .busy               (busy_a)
    );

    rx_bit_timer #(.CLKS_PER_BIT(9), .DATA_BITS(5)) u_dut_b (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_b),
        .stop_bit           (stop_b),
        .shift_strobe       (strobe_b),
        .packet_done        (pd_b),
        .load_buffer        (lb_b),
        .framing_error      (fe_b),
        .busy               (busy_b)
    );

    int tests = 0;
    int fails = 0;

    logic [4:0] log_buf  [0:199];
    logic [4:0] log_good [0:199];
    logic [4:0] log_bad  [0:199];

    typedef struct {
        int         period;
        logic       stop;
        logic [4:0] exp;
    } vec_t;

    vec_t vt [0:13];

    task automatic check(input string name, input int p, input logic [4:0] act,
                         input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s period %0d: got %b expected %b", name, p, act, exp);
        end
    endtask

    // Drive a start pulse into edge 0, then capture periods 0..n-1.
    task automatic run_frame(input int dut, input logic stop, input bit extra,
                             input int n);
        @(negedge clk);
        if (dut == 0) begin
            start_a = 1'b1;
            stop_a  = stop;
        end else begin
            start_b = 1'b1;
            stop_b  = stop;
        end
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            log_buf[p] = (dut == 0) ? obs_a : obs_b;
            start_a = 1'b0;
            start_b = 1'b0;
            if (extra && (p + 1 == 40 || p + 1 == 100)) start_a = 1'b1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Reference timing derived from the frame structure.
    function automatic logic [4:0] model(input int c, input int d, input logic stop,
                                         input int p);
        logic s, pd, lb, fe, b;
        int   chk;
        chk = (d + 2) * c;
        s   = (p % c == c / 2) && (p / c >= 1) && (p / c <= d + 1);
        pd  = (p == chk);
        lb  = stop && (p == chk + 1);
        fe  = !stop && (p >= chk + 1);
        b   = (p <= chk + (stop ? 1 : 0));
        return {s, pd, lb, fe, b};
    endfunction

    task automatic check_model(input string name, input int c, input int d,
                               input logic stop, input int n);
        for (int p = 0; p < n; p++) begin
            check(name, p, log_buf[p], model(c, d, stop, p));
        end
    endtask

    initial begin
        vt[0]  = '{0,   1'b1, 5'b00001};
        vt[1]  = '{14,  1'b1, 5'b00001};
        vt[2]  = '{15,  1'b1, 5'b10001};
        vt[3]  = '{16,  1'b1, 5'b00001};
        vt[4]  = '{25,  1'b1, 5'b10001};
        vt[5]  = '{95,  1'b1, 5'b10001};
        vt[6]  = '{99,  1'b1, 5'b00001};
        vt[7]  = '{100, 1'b1, 5'b01001};
        vt[8]  = '{101, 1'b1, 5'b00101};
        vt[9]  = '{102, 1'b1, 5'b00000};
        vt[10] = '{100, 1'b0, 5'b01001};
        vt[11] = '{101, 1'b0, 5'b00010};
        vt[12] = '{102, 1'b0, 5'b00010};
        vt[13] = '{130, 1'b0, 5'b00010};

        // Reset held for two edges with start asserted: reset wins.
        n_rst   = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        stop_a  = 1'b1;
        stop_b  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_a", 0, obs_a, 5'b00000);
        check("reset_b", 0, obs_b, 5'b00000);
        n_rst   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("idle_a", 0, obs_a, 5'b00000);

        // Good frame, then framing-error frame.
        run_frame(0, 1'b1, 1'b0, 110);
        log_good = log_buf;
        check_model("good", 10, 8, 1'b1, 110);
        run_frame(0, 1'b0, 1'b0, 140);
        log_bad = log_buf;
        check_model("ferr", 10, 8, 1'b0, 140);

        for (int i = 0; i < 14; i++) begin
            check(vt[i].stop ? "tbl_good" : "tbl_ferr", vt[i].period,
                  vt[i].stop ? log_good[vt[i].period] : log_bad[vt[i].period],
                  vt[i].exp);
        end

        // Next accepted start clears framing_error; extra starts at 40/100
        // must not disturb the frame.
        check("ferr_held", 0, obs_a, 5'b00010);
        run_frame(0, 1'b1, 1'b1, 110);
        check_model("ignored_start", 10, 8, 1'b1, 110);

        // Mid-frame reset at edge 50, fresh start at edge 53.
        @(negedge clk);
        start_a = 1'b1;
        stop_a  = 1'b1;
        for (int p = 0; p < 80; p++) begin
            logic [4:0] e;
            @(negedge clk);
            if (p >= 48) begin
                if (p < 50) e = model(10, 8, 1'b1, p);
                else if (p < 53) e = 5'b00000;
                else e = {((p - 53) % 10 == 5) && ((p - 53) / 10 >= 1),
                          4'b0001};
                check("mid_reset", p, obs_a, e);
            end
            n_rst   = (p + 1 == 50) ? 1'b0 : 1'b1;
            start_a = (p + 1 == 53);
        end
        start_a = 1'b0;
        n_rst   = 1'b0;
        @(negedge clk);
        check("reset_again", 0, obs_a, 5'b00000);
        n_rst = 1'b1;
        @(negedge clk);

        // Parameter sweep: CLKS_PER_BIT=9, DATA_BITS=5.
        run_frame(1, 1'b1, 1'b0, 70);
        check_model("sweep", 9, 5, 1'b1, 70);
        check("sweep_s13", 13, log_buf[13], 5'b10001);
        check("sweep_s58", 58, log_buf[58], 5'b10001);
        check("sweep_chk", 63, log_buf[63], 5'b01001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
